// File: rtl/ram_io_responder_pkg.sv
// ram_io_responder_pkg
// Shared constants and request decode for the RAM/I-O responder.
//   UnsignedCharLength : byte width of the RAM data path
//   PcLength           : width of the fetcher's byte address
//   IoRegionTag/IoTagHi/IoTagLo : addr[17:16] == 2'b11 selects the I/O region
//   NullAddr           : parking address; stores to it are ignored
//   req_e/decode_req   : classify one request cycle
package ram_io_responder_pkg;

  localparam int unsigned UnsignedCharLength = 8;
  localparam int unsigned PcLength           = 32;

  localparam logic [1:0]          IoRegionTag = 2'b11;
  localparam int unsigned         IoTagHi     = 17;
  localparam int unsigned         IoTagLo     = 16;
  localparam logic [PcLength-1:0] NullAddr    = '0;

  typedef enum logic [2:0] {
    ReqIdle,
    ReqRamRead,
    ReqRamWrite,
    ReqIoRead,
    ReqIoWrite
  } req_e;

  function automatic req_e decode_req(input logic                rdy,
                                      input logic                is_store,
                                      input logic [PcLength-1:0] addr);
    logic is_io;
    is_io = (addr[IoTagHi:IoTagLo] == IoRegionTag);
    if (!rdy) begin
      return ReqIdle;
    end else if (is_io) begin
      return is_store ? ReqIoWrite : ReqIoRead;
    end else if (!is_store) begin
      return ReqRamRead;
    end else if (addr != NullAddr) begin
      return ReqRamWrite;
    end
    // Store to the parking address: the fetcher is idle, not writing.
    return ReqIdle;
  endfunction

endpackage

// File: rtl/ram_io_responder_byte_fifo.sv
// ram_io_responder_byte_fifo
// Byte FIFO with synchronous active-low reset and power-of-two depth.
//   i_clk, i_rst_n   : clock, synchronous active-low reset
//   i_push, i_data   : write request and byte (accepted if not full or popping)
//   i_pop            : read request (ignored when empty)
//   o_head_data      : byte at head, combinational from head pointer
//   o_empty, o_full  : occupancy flags for the current count
//   o_count_next     : occupancy after this cycle's accepted push/pop
module ram_io_responder_byte_fifo #(
  parameter int unsigned Depth     = 8,
  parameter int unsigned PtrWidth  = 3,
  parameter int unsigned DataWidth = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_push,
  input  logic [DataWidth-1:0] i_data,
  input  logic                 i_pop,
  output logic [DataWidth-1:0] o_head_data,
  output logic                 o_empty,
  output logic                 o_full,
  output logic [PtrWidth:0]    o_count_next
);

  localparam logic [PtrWidth:0] DepthCount = (PtrWidth + 1)'(Depth);

  logic [DataWidth-1:0] r_mem [Depth];
  logic [PtrWidth-1:0]  r_head;
  logic [PtrWidth-1:0]  r_tail;
  logic [PtrWidth:0]    r_count;

  logic              w_pop;
  logic              w_push;
  logic [PtrWidth:0] w_count_next;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == DepthCount);

  assign w_pop  = i_pop & ~o_empty;
  // When full, a same-cycle pop frees the head slot before the write lands.
  assign w_push = i_push & (~o_full | w_pop);

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + (PtrWidth + 1)'(1);
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - (PtrWidth + 1)'(1);
    end
  end

  assign o_count_next = w_count_next;
  assign o_head_data  = r_mem[r_head];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
      if (w_push) r_tail <= r_tail + PtrWidth'(1);
      if (w_pop)  r_head <= r_head + PtrWidth'(1);
    end
  end

  // Storage carries no reset; stale bytes are unreachable once pointers clear.
  always_ff @(posedge i_clk) begin
    if (w_push && i_rst_n) begin
      r_mem[r_tail] <= i_data;
    end
  end

endmodule

// File: rtl/ram_io_responder.sv
// ram_io_responder
// Byte-serial main-memory model plus console TX FIFO behind the fetcher's RAM port.
//   i_clk, i_rst_n     : clock, synchronous active-low reset
//   i_rdy              : global enable; low freezes the request side
//   i_addr, i_is_store : byte address and read/write select from the fetcher
//   i_data_in          : write byte
//   o_data_out         : registered read byte (1-cycle latency)
//   o_is_full_to_fc    : registered I/O back-pressure, one spare slot
//   o_tx_data/o_tx_valid/i_tx_ready : console byte stream
//   o_overflow         : sticky, an I/O store was dropped on a full FIFO
module ram_io_responder
  import ram_io_responder_pkg::*;
#(
  parameter int unsigned AddrWidth    = 17,
  parameter int unsigned FifoDepth    = 8,
  parameter int unsigned FifoPtrWidth = 3
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_rdy,
  input  logic [PcLength-1:0]           i_addr,
  input  logic                          i_is_store,
  input  logic [UnsignedCharLength-1:0] i_data_in,
  output logic [UnsignedCharLength-1:0] o_data_out,
  output logic                          o_is_full_to_fc,
  output logic [UnsignedCharLength-1:0] o_tx_data,
  output logic                          o_tx_valid,
  input  logic                          i_tx_ready,
  output logic                          o_overflow
);

  // Raise the flag one entry early: the fetcher registers it and may still
  // issue one more store after it goes high.
  localparam logic [FifoPtrWidth:0] FullThresh = (FifoPtrWidth + 1)'(FifoDepth - 1);

  logic [UnsignedCharLength-1:0] r_mem [2**AddrWidth];
  logic [UnsignedCharLength-1:0] r_data_out;
  logic                          r_is_full_to_fc;
  logic                          r_overflow;

  req_e                  w_req;
  logic [AddrWidth-1:0]  w_ram_idx;
  logic                  w_io_store;
  logic                  w_pop;
  logic                  w_fifo_empty;
  logic                  w_fifo_full;
  logic [FifoPtrWidth:0] w_count_next;

  assign w_req      = decode_req(i_rdy, i_is_store, i_addr);
  assign w_ram_idx  = i_addr[AddrWidth-1:0];
  assign w_io_store = (w_req == ReqIoWrite);

  // Drain is independent of i_rdy.
  assign w_pop = ~w_fifo_empty & i_tx_ready;

  ram_io_responder_byte_fifo #(
    .Depth    (FifoDepth),
    .PtrWidth (FifoPtrWidth),
    .DataWidth(UnsignedCharLength)
  ) u_tx_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (w_io_store),
    .i_data      (i_data_in),
    .i_pop       (w_pop),
    .o_head_data (o_tx_data),
    .o_empty     (w_fifo_empty),
    .o_full      (w_fifo_full),
    .o_count_next(w_count_next)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst_n && (w_req == ReqRamWrite)) begin
      r_mem[w_ram_idx] <= i_data_in;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_data_out      <= '0;
      r_is_full_to_fc <= 1'b0;
      r_overflow      <= 1'b0;
    end else begin
      r_is_full_to_fc <= (w_count_next >= FullThresh);
      if (w_io_store && w_fifo_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
      case (w_req)
        ReqRamRead: r_data_out <= r_mem[w_ram_idx];
        ReqIoRead:  r_data_out <= '0;
        default:    r_data_out <= r_data_out;
      endcase
    end
  end

  assign o_data_out      = r_data_out;
  assign o_is_full_to_fc = r_is_full_to_fc;
  assign o_overflow      = r_overflow;
  assign o_tx_valid      = ~w_fifo_empty;

endmodule

// File: tb/tb_ram_io_responder.sv
// tb_ram_io_responder
// Directed self-checking bench for ram_io_responder.
module tb_ram_io_responder;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic [31:0] addr;
  logic        is_store;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        is_full_to_fc;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  ram_io_responder dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_rdy          (rdy),
    .i_addr         (addr),
    .i_is_store     (is_store),
    .i_data_in      (data_in),
    .o_data_out     (data_out),
    .o_is_full_to_fc(is_full_to_fc),
    .o_tx_data      (tx_data),
    .o_tx_valid     (tx_valid),
    .i_tx_ready     (tx_ready),
    .o_overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic st, input logic [31:0] a, input logic [7:0] d);
    is_store = st;
    addr     = a;
    data_in  = d;
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; tx_ready = 1'b0;
    req(1'b0, 32'h0, 8'h00);
    tick(); tick();
    check("rst_data_out", data_out, 8'h00);
    check("rst_tx_valid", {7'd0, tx_valid}, 8'h00);
    check("rst_full", {7'd0, is_full_to_fc}, 8'h00);
    check("rst_overflow", {7'd0, overflow}, 8'h00);
    rst_n = 1'b1;

    // RAM write then read-back
    req(1'b1, 32'h0000_0100, 8'hA5); tick();
    check("write_holds_data_out", data_out, 8'h00);
    req(1'b0, 32'h0000_0100, 8'h00); tick();
    check("read_after_write", data_out, 8'hA5);

    // 0x20000 aliases mem[0]; null-address store is ignored
    req(1'b1, 32'h0002_0000, 8'h77); tick();
    req(1'b1, 32'h0000_0000, 8'h5A); tick();
    req(1'b0, 32'h0000_0000, 8'h00); tick();
    check("null_store_ignored", data_out, 8'h77);

    // Fill FIFO with I/O stores, sink stalled
    for (int i = 0; i < 8; i++) begin
      req(1'b1, 32'h0003_0000, 8'(8'h41 + i)); tick();
      check($sformatf("fill_full_%0d", i + 1), {7'd0, is_full_to_fc}, {7'd0, (i + 1) >= 7});
    end
    check("fill_no_overflow", {7'd0, overflow}, 8'h00);
    req(1'b1, 32'hFFF3_0000, 8'h49); tick();
    check("ninth_overflow", {7'd0, overflow}, 8'h01);
    req(1'b0, 32'h0003_0000, 8'h00); tick();
    check("io_read_zero", data_out, 8'h00);
    req(1'b0, 32'h0000_0000, 8'h00);

    // Drain
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_valid_%0d", i), {7'd0, tx_valid}, 8'h01);
      check($sformatf("drain_data_%0d", i), tx_data, 8'(8'h41 + i));
      tick();
      check($sformatf("drain_full_%0d", i), {7'd0, is_full_to_fc}, {7'd0, (7 - i) >= 7});
    end
    check("drain_empty", {7'd0, tx_valid}, 8'h00);
    check("overflow_sticky", {7'd0, overflow}, 8'h01);
    tx_ready = 1'b0;

    // Reset clears overflow, then full FIFO with simultaneous push and pop
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("overflow_cleared", {7'd0, overflow}, 8'h00);
    for (int i = 0; i < 8; i++) begin
      req(1'b1, 32'h0003_0000, 8'(8'h61 + i)); tick();
    end
    req(1'b1, 32'h0003_0000, 8'h69);
    tx_ready = 1'b1;
    check("pushpop_head", tx_data, 8'h61);
    tick();
    check("pushpop_no_overflow", {7'd0, overflow}, 8'h00);
    check("pushpop_full", {7'd0, is_full_to_fc}, 8'h01);
    req(1'b0, 32'h0000_0000, 8'h00);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("pushpop_data_%0d", i), tx_data, 8'(8'h62 + i));
      tick();
    end
    check("pushpop_empty", {7'd0, tx_valid}, 8'h00);
    tx_ready = 1'b0;

    // rdy low freezes the request side
    req(1'b0, 32'h0000_0100, 8'h00); tick();
    check("pre_freeze_read", data_out, 8'hA5);
    rdy = 1'b0;
    req(1'b1, 32'h0000_0100, 8'hEE); tick();
    check("freeze_write_hold", data_out, 8'hA5);
    req(1'b0, 32'h0002_0000, 8'h00); tick();
    check("freeze_read_hold", data_out, 8'hA5);
    req(1'b1, 32'h0003_0000, 8'h11); tick();
    check("freeze_no_push", {7'd0, tx_valid}, 8'h00);
    rdy = 1'b1;
    req(1'b0, 32'h0000_0100, 8'h00); tick();
    check("freeze_mem_unchanged", data_out, 8'hA5);

    // Reset mid-drain
    for (int i = 0; i < 3; i++) begin
      req(1'b1, 32'h0003_0000, 8'(8'h31 + i)); tick();
    end
    req(1'b0, 32'h0000_0100, 8'h00);
    tx_ready = 1'b1; tick();
    check("middrain_head", tx_data, 8'h32);
    check("middrain_data_out", data_out, 8'hA5);
    rst_n = 1'b0; tick();
    check("middrain_rst_valid", {7'd0, tx_valid}, 8'h00);
    check("middrain_rst_data_out", data_out, 8'h00);
    check("middrain_rst_full", {7'd0, is_full_to_fc}, 8'h00);
    rst_n = 1'b1; tx_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
